// File: rtl/data_bus_bridge_if.sv
// ---------------------------------------------------------------------------
// data_bus_bridge_if
//
// Bundles the memory-stage request side and the external data-bus side of
// the data bus bridge.
//
//   Pipeline side : ram_en, ram_write_en[3:0], ram_addr[31:0],
//                   ram_write_data[31:0], flush          (into the bridge)
//                   stall_req, read_data[31:0]           (out of the bridge)
//   Bus side      : bus_req, bus_we[3:0], bus_addr[31:0],
//                   bus_wdata[31:0], bus_error           (out of the bridge)
//                   bus_ack, bus_rdata[31:0]             (into the bridge)
//
// Modports:
//   slave  - the bridge itself
//   master - the environment around it (pipeline plus bus responder)
// ---------------------------------------------------------------------------
interface data_bus_bridge_if;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic        flush;
  logic        stall_req;
  logic [31:0] read_data;
  logic        bus_req;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_error;

  modport slave (
    input  ram_en, ram_write_en, ram_addr, ram_write_data, flush,
    input  bus_ack, bus_rdata,
    output stall_req, read_data,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_error
  );

  modport master (
    output ram_en, ram_write_en, ram_addr, ram_write_data, flush,
    output bus_ack, bus_rdata,
    input  stall_req, read_data,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_error
  );
endinterface

// File: rtl/data_bus_bridge.sv
// ---------------------------------------------------------------------------
// data_bus_bridge
//
// Turns a single-cycle load/store request from the memory stage into a
// multi-cycle external bus transaction, stalling the pipeline until the bus
// acknowledges. A load's data is registered into read_data for writeback.
//
// Ports:
//   clk  - single clock for all state
//   rst  - synchronous, active-low reset
//   bif  - data_bus_bridge_if.slave (pipeline request side + bus side)
//
// Parameter:
//   TIMEOUT_CYCLES - ack-less BUSY cycles tolerated before an abort (1..255)
//
// Build option:
//   DBRIDGE_TIMEOUT_EN - when defined, compiles in the timeout watchdog that
//   aborts a hung transaction and pulses bus_error. When undefined, BUSY waits
//   for bus_ack indefinitely and bus_error is tied low.
//
// FSM: IDLE -> BUSY (request accepted) -> DONE (one cycle, stall released so
// the instruction can retire) -> IDLE. A transaction whose instruction was
// flushed while on the bus completes silently straight back to IDLE.
// ---------------------------------------------------------------------------
module data_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              rst,
  data_bus_bridge_if.slave bif
);

  // The watchdog counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("data_bus_bridge: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic        discard;    // owning instruction was flushed while on the bus
  logic [3:0]  we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] read_data_q;
  logic        accept;

  // A new request is only taken from IDLE; DONE deliberately ignores ram_en
  // because it still belongs to the instruction that just completed.
  assign accept = (state == IDLE) && bif.ram_en && !bif.flush;

  assign bif.stall_req = accept || (state == BUSY);
  assign bif.bus_req   = (state == BUSY);
  assign bif.bus_we    = we_q;
  assign bif.bus_addr  = addr_q;
  assign bif.bus_wdata = wdata_q;
  assign bif.read_data = read_data_q;

`ifdef DBRIDGE_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] wait_cnt;
  logic       error_q;

  assign bif.bus_error = error_q;
`else
  assign bif.bus_error = 1'b0;
`endif

  // NOTE: all state lives in this one clocked block and uses non-blocking
  // assignments, so every register samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    // NOTE: the data registers are cleared in reset too, because read_data
    // and the bus_* copies are visible outputs and must come up as zero.
    if (!rst) begin
      state       <= IDLE;
      discard     <= 1'b0;
      we_q        <= 4'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      read_data_q <= 32'd0;
`ifdef DBRIDGE_TIMEOUT_EN
      wait_cnt    <= 8'd0;
      error_q     <= 1'b0;
`endif
    end else begin
`ifdef DBRIDGE_TIMEOUT_EN
      error_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= bif.ram_write_en;
            addr_q  <= bif.ram_addr;
            wdata_q <= bif.ram_write_data;
            discard <= 1'b0;
`ifdef DBRIDGE_TIMEOUT_EN
            wait_cnt <= 8'd0;
`endif
            state   <= BUSY;
          end
        end

        BUSY: begin
          if (bif.bus_ack) begin
            // Ack beats a same-cycle timeout. Loads of flushed instructions
            // must not disturb read_data, which may still feed writeback.
            if (!discard && (we_q == 4'd0)) begin
              read_data_q <= bif.bus_rdata;
            end
            discard <= 1'b0;
            state   <= discard ? IDLE : DONE;
          end
`ifdef DBRIDGE_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_LIMIT) begin
            if (!discard && (we_q == 4'd0)) begin
              read_data_q <= 32'd0;
            end
            error_q <= 1'b1;
            discard <= 1'b0;
            state   <= discard ? IDLE : DONE;
          end
`endif
          else begin
            // The bus cycle cannot be cancelled, so a flush is only recorded.
            if (bif.flush) begin
              discard <= 1'b1;
            end
`ifdef DBRIDGE_TIMEOUT_EN
            wait_cnt <= wait_cnt + 8'd1;
`endif
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_data_bus_bridge
//
// Drives data_bus_bridge through directed scenarios and a randomized phase.
// A transaction-level model (is a bus transaction in flight, was last cycle
// the retire cycle, how many unanswered bus cycles so far) predicts every
// output; one process compares DUT against it on each falling edge, and the
// directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_data_bus_bridge;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;

  data_bus_bridge_if bif();

  data_bus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  always #5 clk = ~clk;

  int n_vec   = 0;
  int n_err   = 0;
  int n_issue = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          model_live = 0;
  bit          m_inflight, m_retire, m_err, m_discard;
  int          m_unanswered;
  logic [3:0]  m_we;
  logic [31:0] m_addr, m_wdata, m_rd;

  // Ends the in-flight transaction; aborted loads read as zero.
  task automatic m_finish(input bit aborted, input logic [31:0] data);
    if (!m_discard && m_we == 4'd0) m_rd = aborted ? 32'd0 : data;
    m_err      = aborted;
    m_retire   = !m_discard;
    m_inflight = 0;
    m_discard  = 0;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      model_live = 1;
      m_inflight = 0; m_retire = 0; m_err = 0; m_discard = 0;
      m_unanswered = 0;
      m_we = '0; m_addr = '0; m_wdata = '0; m_rd = '0;
    end else begin
      m_err = 0;
      if (m_retire) begin
        m_retire = 0;
      end else if (!m_inflight) begin
        if (bif.ram_en && !bif.flush) begin
          m_inflight = 1; m_unanswered = 0; m_discard = 0;
          m_we = bif.ram_write_en; m_addr = bif.ram_addr; m_wdata = bif.ram_write_data;
        end
      end else if (bif.bus_ack) begin
        m_finish(0, bif.bus_rdata);
      end
`ifdef DBRIDGE_TIMEOUT_EN
      else if (m_unanswered == TO) begin
        m_finish(1, 32'd0);
      end
`endif
      else begin
        m_unanswered++;
        if (bif.flush) m_discard = 1;
      end
    end
  end

  // ---------------- compare process ----------------
  logic prev_req = 1'b0;

  always @(negedge clk) begin
    if (model_live) begin
      check("bus_req",   bif.bus_req,   m_inflight);
      check("stall_req", bif.stall_req,
            m_inflight || (!m_retire && bif.ram_en && !bif.flush));
      check("bus_we",    bif.bus_we,    m_we);
      check("bus_addr",  bif.bus_addr,  m_addr);
      check("bus_wdata", bif.bus_wdata, m_wdata);
      check("read_data", bif.read_data, m_rd);
      check("bus_error", bif.bus_error, m_err);
      if (bif.bus_req && !prev_req) n_issue++;
      prev_req = bif.bus_req;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit en, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit fl, input bit ack,
                       input logic [31:0] rdata);
    bif.ram_en = en; bif.ram_write_en = we; bif.ram_addr = addr;
    bif.ram_write_data = wdata; bif.flush = fl; bif.bus_ack = ack; bif.bus_rdata = rdata;
  endtask

  task automatic idle();
    drive(0, 4'd0, 32'd0, 32'd0, 0, 0, 32'd0);
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    rst = 1'b0;
    idle();
    next();
    mid();
    check("rst_req",   bif.bus_req,   1'b0);
    check("rst_stall", bif.stall_req, 1'b0);
    check("rst_err",   bif.bus_error, 1'b0);
    check("rst_rdata", bif.read_data, 32'd0);
    check("rst_addr",  bif.bus_addr,  32'd0);
    next();
    rst = 1'b1;
    idle(); mid(); next();

    // Read acked in its first bus cycle.
    drive(1, 4'd0, 32'h8000_1000, 32'd0, 0, 0, 32'd0); mid();
    check("rd_c0_stall", bif.stall_req, 1'b1);
    check("rd_c0_req",   bif.bus_req,   1'b0); next();
    drive(1, 4'd0, 32'h8000_1000, 32'd0, 0, 1, 32'hDEAD_BEEF); mid();
    check("rd_c1_req",   bif.bus_req,   1'b1);
    check("rd_c1_stall", bif.stall_req, 1'b1);
    check("rd_c1_addr",  bif.bus_addr,  32'h8000_1000); next();
    drive(1, 4'd0, 32'h8000_1000, 32'd0, 0, 0, 32'd0); mid();
    check("rd_c2_req",   bif.bus_req,   1'b0);
    check("rd_c2_stall", bif.stall_req, 1'b0);
    check("rd_c2_data",  bif.read_data, 32'hDEAD_BEEF); next();
    idle(); mid(); next();

    // Store acked in cycle 4.
    drive(1, 4'hC, 32'h8000_2000, 32'h1234_0000, 0, 0, 32'd0); mid(); next();
    for (int c = 1; c <= 4; c++) begin
      drive(1, 4'hC, 32'h8000_2000, 32'h1234_0000, 0, c == 4, 32'hFFFF_FFFF); mid();
      check("st_req",   bif.bus_req,   1'b1);
      check("st_we",    bif.bus_we,    4'hC);
      check("st_addr",  bif.bus_addr,  32'h8000_2000);
      check("st_wdata", bif.bus_wdata, 32'h1234_0000);
      next();
    end
    drive(1, 4'hC, 32'h8000_2000, 32'h1234_0000, 0, 0, 32'd0); mid();
    check("st_c5_stall", bif.stall_req, 1'b0);
    check("st_c5_data",  bif.read_data, 32'hDEAD_BEEF); next();
    idle(); mid(); next();

    // Back-to-back reads: exactly two bus transactions.
    base = n_issue;
    drive(1, 4'd0, 32'h8000_3000, 32'd0, 0, 0, 32'd0); mid(); next();
    drive(1, 4'd0, 32'h8000_3000, 32'd0, 0, 1, 32'h1111_0001); mid(); next();
    drive(1, 4'd0, 32'h8000_3000, 32'd0, 0, 0, 32'd0); mid();
    check("b2b_done_stall", bif.stall_req, 1'b0); next();
    drive(1, 4'd0, 32'h8000_3004, 32'd0, 0, 0, 32'd0); mid();
    check("b2b_second_stall", bif.stall_req, 1'b1); next();
    drive(1, 4'd0, 32'h8000_3004, 32'd0, 0, 1, 32'h2222_0002); mid();
    check("b2b_second_addr", bif.bus_addr, 32'h8000_3004); next();
    drive(1, 4'd0, 32'h8000_3004, 32'd0, 0, 0, 32'd0); mid();
    check("b2b_data", bif.read_data, 32'h2222_0002); next();
    idle(); mid(); next();
    idle(); mid();
    check("b2b_count", n_issue - base, 2); next();

    // Flush during a read: silent completion, straight back to IDLE.
    drive(1, 4'd0, 32'h8000_4000, 32'd0, 0, 0, 32'd0); mid(); next();
    drive(1, 4'd0, 32'h8000_4000, 32'd0, 0, 0, 32'd0); mid(); next();
    drive(1, 4'd0, 32'h8000_4000, 32'd0, 1, 0, 32'd0); mid(); next();
    drive(1, 4'd0, 32'h8000_4000, 32'd0, 0, 1, 32'hBAD0_BAD0); mid(); next();
    drive(1, 4'd0, 32'h8000_5000, 32'd0, 0, 0, 32'd0); mid();
    check("fl_c4_stall", bif.stall_req, 1'b1);
    check("fl_c4_req",   bif.bus_req,   1'b0);
    check("fl_c4_data",  bif.read_data, 32'h2222_0002); next();
    drive(1, 4'd0, 32'h8000_5000, 32'd0, 0, 1, 32'h0D0D_0D0D); mid();
    check("fl_new_addr", bif.bus_addr, 32'h8000_5000); next();
    drive(1, 4'd0, 32'h8000_5000, 32'd0, 0, 0, 32'd0); mid();
    check("fl_new_data", bif.read_data, 32'h0D0D_0D0D); next();
    idle(); mid(); next();

    // Read that is never acknowledged.
    drive(1, 4'd0, 32'h8000_6000, 32'd0, 0, 0, 32'd0); mid(); next();
`ifdef DBRIDGE_TIMEOUT_EN
    for (int c = 1; c <= TO + 1; c++) begin
      drive(1, 4'd0, 32'h8000_6000, 32'd0, 0, 0, 32'd0); mid();
      check("to_wait_req", bif.bus_req,   1'b1);
      check("to_wait_err", bif.bus_error, 1'b0); next();
    end
    drive(1, 4'd0, 32'h8000_6000, 32'd0, 0, 0, 32'd0); mid();
    check("to_err",   bif.bus_error, 1'b1);
    check("to_req",   bif.bus_req,   1'b0);
    check("to_stall", bif.stall_req, 1'b0);
    check("to_data",  bif.read_data, 32'd0); next();
    idle(); mid();
    check("to_err_once", bif.bus_error, 1'b0); next();
`else
    for (int c = 1; c <= 40; c++) begin
      drive(1, 4'd0, 32'h8000_6000, 32'd0, 0, 0, 32'd0); mid();
      check("hang_stall", bif.stall_req, 1'b1);
      check("hang_err",   bif.bus_error, 1'b0); next();
    end
    drive(1, 4'd0, 32'h8000_6000, 32'd0, 0, 1, 32'h6060_6060); mid(); next();
    drive(1, 4'd0, 32'h8000_6000, 32'd0, 0, 0, 32'd0); mid();
    check("hang_data", bif.read_data, 32'h6060_6060); next();
    idle(); mid(); next();
`endif

    // Reset in the middle of BUSY, then a normal read.
    drive(1, 4'd0, 32'h8000_7000, 32'd0, 0, 0, 32'd0); mid(); next();
    drive(1, 4'd0, 32'h8000_7000, 32'd0, 0, 0, 32'd0); mid(); next();
    rst = 1'b0;
    drive(1, 4'd0, 32'h8000_7000, 32'd0, 0, 0, 32'd0); mid();
    check("mr_pre_req", bif.bus_req, 1'b1); next();
    rst = 1'b1;
    idle(); mid();
    check("mr_req",   bif.bus_req,   1'b0);
    check("mr_stall", bif.stall_req, 1'b0);
    check("mr_data",  bif.read_data, 32'd0);
    check("mr_addr",  bif.bus_addr,  32'd0); next();
    drive(0, 4'd0, 32'd0, 32'd0, 0, 1, 32'h7777_7777); mid();
    check("mr_no_pending", bif.bus_req, 1'b0); next();
    drive(1, 4'd0, 32'h8000_8000, 32'd0, 0, 0, 32'd0); mid(); next();
    drive(1, 4'd0, 32'h8000_8000, 32'd0, 0, 1, 32'h5A5A_A5A5); mid(); next();
    drive(1, 4'd0, 32'h8000_8000, 32'd0, 0, 0, 32'd0); mid();
    check("mr_read_data", bif.read_data, 32'h5A5A_A5A5); next();
    idle(); mid(); next();

    // Randomized traffic, checked by the model on every cycle.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] we;
      bit ack, fl;
      we  = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      ack = ($urandom_range(0, 2) == 0);
      fl  = !ack && ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 299) != 0);
      drive($urandom_range(0, 1) != 0, we, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
            $urandom, fl, ack, $urandom);
      mid(); next();
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 4'd0, 32'd0, 32'd0, 0, 1, 32'd0); mid(); next();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
